// File: rtl/tw_sched_pkg.sv
// ============================================================================
// Module      : tw_sched_pkg
// Description : Shared types and latency helpers for the SDF NTT sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tw_sched_pkg;

  localparam int TW_DEF_LOG2N = 3;
  localparam int STAGES       = TW_DEF_LOG2N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tw_state_e;

  // Delay-line depth of stage k.
  function automatic int tw_d(input int log2n, input int k);
    return 1 << (log2n - 1 - k);
  endfunction

  // Advance count at which stage s sees the first sample of a job.
  function automatic int tw_lat(input int log2n, input int bf_lat, input int s);
    int acc;
    acc = 0;
    for (int k = 0; k < s; k++) begin
      acc += tw_d(log2n, k) + bf_lat;
    end
    return acc;
  endfunction

  function automatic int tw_lat_t(input int log2n, input int bf_lat);
    return tw_lat(log2n, bf_lat, log2n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tw_stage_addr_gen.sv
// ============================================================================
// Module      : tw_stage_addr_gen
// Description : Per-stage active flag, butterfly mode and twiddle address.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tw_stage_addr_gen
  import tw_sched_pkg::*;
#(
  parameter int LOG2N  = STAGES,
  parameter int ADDR_W = 3,
  parameter int AW     = 20,
  parameter int LAT_S  = 0,
  parameter int STAGE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [AW-1:0]     adv_i,
  input  logic [AW-1:0]     tot_i,
  output logic              act_o,
  output logic              bf_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [AW-1:0]     C_LAT  = AW'(LAT_S);
  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'((1 << STAGE) - 1);
  localparam int                C_SH   = LOG2N - STAGE;

  logic [AW-1:0]     w_g;
  logic              w_act;
  logic [LOG2N-1:0]  w_j;
  logic [LOG2N-1:0]  w_hi;
  logic              w_bf;
  logic [ADDR_W-1:0] w_addr;

  logic              act_q;
  logic              bf_q;
  logic [ADDR_W-1:0] addr_q;

  // adv_i is the advance index this stage's fields will describe after the edge.
  assign w_g    = adv_i - C_LAT;
  assign w_act  = (adv_i >= C_LAT) && (w_g < tot_i);
  assign w_j    = w_g[LOG2N-1:0];
  assign w_hi   = w_j >> C_SH;
  assign w_bf   = w_j[LOG2N-1-STAGE];
  assign w_addr = C_BASE + ADDR_W'(w_hi);

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q  <= 1'b0;
      bf_q   <= 1'b0;
      addr_q <= '0;
    end else if (en_i) begin
      act_q  <= w_act;
      bf_q   <= w_act & w_bf;
      addr_q <= w_act ? w_addr : '0;
    end
  end

  assign act_o  = act_q;
  assign bf_o   = bf_q;
  assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/tw_sched_ctrl.sv
// ============================================================================
// Module      : tw_sched_ctrl
// Description : Frame sequencer for the SDF NTT pipeline and twiddle ROMs.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tw_sched_ctrl
  import tw_sched_pkg::*;
#(
  parameter int LOG2N  = STAGES,
  parameter int BF_LAT = 1,
  parameter int FRM_W  = 16,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FRM_W-1:0]        cfg_frames,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    pipe_en,
  output logic [LOG2N*ADDR_W-1:0] stage_tw_addr,
  output logic [LOG2N-1:0]        stage_bf,
  output logic [LOG2N-1:0]        stage_act,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int            AW      = FRM_W + LOG2N + 1;
  localparam logic [AW-1:0] C_LAT_T = AW'(tw_lat_t(LOG2N, BF_LAT));
  localparam logic [AW-1:0] C_ONE   = AW'(1);

  tw_state_e     state_q;
  logic [AW-1:0] adv_q;
  logic [AW-1:0] adv_d;
  logic [AW-1:0] tot_q;
  logic          done_q;
  logic          busy_q;
  logic          in_ready_q;

  logic [AW-1:0] w_tot_cfg;
  logic [AW-1:0] w_tot_sel;
  logic          w_load;
  logic          w_pipe;
  logic          w_stage_en;

  assign w_tot_cfg  = {1'b0, cfg_frames, {LOG2N{1'b0}}};
  assign w_load     = (state_q == ST_IDLE) && start && (cfg_frames != '0);
  assign w_pipe     = ((state_q == ST_RUN) && in_valid) || (state_q == ST_DRAIN);
  assign adv_d      = w_load ? '0 : adv_q + C_ONE;
  assign w_tot_sel  = w_load ? w_tot_cfg : tot_q;
  assign w_stage_en = w_load | w_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      adv_q      <= '0;
      tot_q      <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_frames != '0) begin
              state_q    <= ST_RUN;
              tot_q      <= w_tot_cfg;
              adv_q      <= '0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            adv_q <= adv_d;
            if (adv_q == tot_q - C_ONE) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          adv_q <= adv_d;
          // Last drain advance: the final sample has just left the last stage.
          if (adv_q == tot_q + C_LAT_T - C_ONE) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    tw_stage_addr_gen #(
      .LOG2N  (LOG2N),
      .ADDR_W (ADDR_W),
      .AW     (AW),
      .LAT_S  (tw_lat(LOG2N, BF_LAT, s)),
      .STAGE  (s)
    ) u_gen (
      .clk    (clk),
      .rst    (rst),
      .en_i   (w_stage_en),
      .adv_i  (adv_d),
      .tot_i  (w_tot_sel),
      .act_o  (stage_act[s]),
      .bf_o   (stage_bf[s]),
      .addr_o (stage_tw_addr[s*ADDR_W +: ADDR_W])
    );
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pipe_en   = w_pipe;
  assign out_valid = w_pipe && (adv_q >= C_LAT_T) && ((adv_q - C_LAT_T) < tot_q);

endmodule

`default_nettype wire
